// File: rtl/coin_vend_ctrl_if.sv
// Bundle of the coin acceptor, dispenser handshake and display signals of the
// vending controller.
//   coin      : 2-bit coin code (00=25, 01=50, 10=100, 11=none)
//   cancel    : refund request (level)
//   vend_ack  : dispenser has taken the item (level)
//   done      : item paid, waiting for vend_ack
//   busy      : controller not idle
//   coin_rej  : one-cycle pulse, the last sampled coin was returned
//   chg_pulse : one-cycle pulse, release one 25-paise coin
//   seg_*     : active-low 7-segment digits {g,f,e,d,c,b,a}
// master drives the inputs of the controller, slave is the controller itself.
interface coin_vend_ctrl_if;
  logic [1:0] coin;
  logic       cancel;
  logic       vend_ack;
  logic       done;
  logic       busy;
  logic       coin_rej;
  logic       chg_pulse;
  logic [6:0] seg_hun;
  logic [6:0] seg_ten;
  logic [6:0] seg_one;

  modport master (
    output coin, cancel, vend_ack,
    input  done, busy, coin_rej, chg_pulse, seg_hun, seg_ten, seg_one
  );

  modport slave (
    input  coin, cancel, vend_ack,
    output done, busy, coin_rej, chg_pulse, seg_hun, seg_ten, seg_one
  );
endinterface

// File: rtl/coin_vend_ctrl.sv
// Coin collector / vend sequencer with programmable price.
// Accumulates 25/50/100-paise coins, holds done until the dispenser acks,
// then pays out overpayment (or the full credit on cancel) as a train of
// 25-paise change pulses. Shows the running amount on three 7-seg digits.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : coin_vend_ctrl_if.slave (coin/cancel/vend_ack in, status and
//           display out)
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | no credit
// COLLECT | 0 < credit < PRICE, accepting coins
// VEND    | credit >= PRICE, done high, waiting for ack
// PAYOUT  | releasing change / refund coins
module coin_vend_ctrl #(
  parameter int PRICE = 100,
  parameter int AMT_W = 10
) (
  input  logic          clock,
  input  logic          reset,
  coin_vend_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    PAYOUT  = 2'd3
  } state_t;

  localparam logic [AMT_W-1:0] PRICE_A = AMT_W'(PRICE);
  localparam logic [AMT_W-1:0] STEP    = AMT_W'(25);

  state_t           state;
  state_t           state_nxt;
  logic [AMT_W-1:0] credit;
  logic [AMT_W-1:0] credit_nxt;
  logic [AMT_W-1:0] payout;
  logic [AMT_W-1:0] payout_nxt;
  logic             chg_q;
  logic             chg_nxt;
  logic             rej_q;
  logic             rej_nxt;
  logic             done_q;
  logic             busy_q;

  logic             coin_vld;
  logic [AMT_W-1:0] coin_val;
  logic [AMT_W-1:0] sum;

  always_comb begin
    coin_vld = (bus.coin != 2'b11);
    case (bus.coin)
      2'b00:   coin_val = AMT_W'(25);
      2'b01:   coin_val = AMT_W'(50);
      2'b10:   coin_val = AMT_W'(100);
      default: coin_val = '0;
    endcase
    // Credit never exceeds PRICE+75, which AMT_W is sized to hold.
    sum = credit + coin_val;
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    payout_nxt = payout;
    chg_nxt    = 1'b0;
    rej_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (coin_vld) begin
          credit_nxt = sum;
          state_nxt  = (sum >= PRICE_A) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          // Refund wins over a coin arriving in the same cycle.
          payout_nxt = credit;
          credit_nxt = '0;
          state_nxt  = PAYOUT;
          chg_nxt    = 1'b1;
          rej_nxt    = coin_vld;
        end else if (coin_vld) begin
          credit_nxt = sum;
          state_nxt  = (sum >= PRICE_A) ? VEND : COLLECT;
        end
      end
      VEND: begin
        rej_nxt = coin_vld;
        if (bus.vend_ack) begin
          payout_nxt = credit - PRICE_A;
          credit_nxt = '0;
          if (credit == PRICE_A) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = PAYOUT;
            chg_nxt   = 1'b1;
          end
        end else if (bus.cancel) begin
          payout_nxt = credit;
          credit_nxt = '0;
          state_nxt  = PAYOUT;
          chg_nxt    = 1'b1;
        end
      end
      PAYOUT: begin
        rej_nxt = coin_vld;
        // chg_q doubles as the phase: the edge closing a pulse cycle
        // pays one coin off, the edge closing a gap cycle starts the next.
        if (chg_q) begin
          payout_nxt = payout - STEP;
          if (payout == STEP) begin
            state_nxt = IDLE;
          end
        end else begin
          chg_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      credit <= '0;
      payout <= '0;
      chg_q  <= 1'b0;
      rej_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      payout <= payout_nxt;
      chg_q  <= chg_nxt;
      rej_q  <= rej_nxt;
      done_q <= (state_nxt == VEND);
      busy_q <= (state_nxt != IDLE);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [AMT_W-1:0] disp_val;
  int               disp_int;
  logic [3:0]       dig_hun;
  logic [3:0]       dig_ten;
  logic [3:0]       dig_one;

  always_comb begin
    disp_val = (state == PAYOUT) ? payout : credit;
    disp_int = int'(disp_val);
    dig_hun  = 4'(disp_int / 100);
    dig_ten  = 4'((disp_int / 10) % 10);
    dig_one  = 4'(disp_int % 10);
  end

  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.coin_rej  = rej_q;
  assign bus.chg_pulse = chg_q;
  assign bus.seg_hun   = seg7(dig_hun);
  assign bus.seg_ten   = seg7(dig_ten);
  assign bus.seg_one   = seg7(dig_one);

endmodule

// File: doc/coin_vend_ctrl.md
# coin_vend_ctrl

Parametrised successor to the fixed-price coin collector. It accumulates 25/50/100-paise coins against a programmable price and holds `done` until the dispenser acknowledges the vend. It then pays out overpayment as change, or refunds the full credit on cancel. It drives a three-digit active-low 7-segment display and sits between the coin acceptor and the product/change dispensers of the vending datapath.

## Interface
- `PRICE`, default 100: item price in paise; multiple of 25, range 25..875.
- `AMT_W`, default 10: width of the credit and payout registers; must satisfy 2^AMT_W > PRICE+75.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `coin` input 2: coin code sampled every rising edge; 00=25, 01=50, 10=100, 11=no coin.
- `cancel` input 1: level; request refund of current credit.
- `vend_ack` input 1: level; dispenser has taken the item.
- `done` output 1: item paid, awaiting `vend_ack`.
- `busy` output 1: high in any state except IDLE.
- `coin_rej` output 1: one-cycle pulse; the coin sampled on this edge was returned.
- `chg_pulse` output 1: one-cycle pulse; each pulse releases one 25-paise coin.
- `seg_hun`, `seg_ten`, `seg_one` output 7 each: hundreds, tens and units digits; bit order {g,f,e,d,c,b,a}, active-low.

## Operation
- States and register behaviour:
  - IDLE: credit=0.
  - COLLECT: 0 < credit < PRICE.
  - VEND: credit ≥ PRICE, `done`=1.
  - PAYOUT: dispensing change or refund.
- Accepted coin: in IDLE or COLLECT, a coin ≠ 11 sets credit ← credit+value on that edge.
  - New credit ≥ PRICE → VEND.
  - Otherwise → COLLECT.
- Maximum credit is PRICE+75, so no overflow occurs.
- Rejected coin: any coin ≠ 11 sampled in VEND or PAYOUT, or in the same cycle as an honoured `cancel`. Credit is unchanged and `coin_rej`=1 for the following cycle.
- VEND behaviour:
  - `vend_ack`=1 → payout ← credit−PRICE, credit ← 0. Go to IDLE if payout=0, else PAYOUT.
  - `cancel`=1 with `vend_ack`=0 → payout ← credit, credit ← 0, go to PAYOUT (full refund).
  - `vend_ack` has priority over `cancel`.
- COLLECT with `cancel`=1 → payout ← credit, credit ← 0, go to PAYOUT.
- IDLE ignores `cancel` and `vend_ack`. COLLECT ignores `vend_ack`.
- PAYOUT:
  - `chg_pulse` alternates 1,0,1,0 starting the first cycle after entry.
  - Payout decrements by 25 on each edge that ends a pulse cycle.
  - After the last pulse, payout=0 and the next state is IDLE.
  - `cancel` and `vend_ack` are ignored.
- Display: shows payout in PAYOUT, credit otherwise, converted to three BCD digits (max 950).
  - Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - No leading-zero blanking.
- Outputs are decoded from registered state only; there are no combinational input-to-output paths.

## Timing
- Reset (`reset`=0, asynchronous):
  - State IDLE; credit=0; payout=0.
  - `done`=`busy`=`coin_rej`=`chg_pulse`=0.
  - All three segment outputs = 1000000.
- Coin to display/`done` latency: 1 edge. The new value is valid immediately after the sampling edge.
- `vend_ack` to `done` deassert: 1 edge.
- First `chg_pulse` is high in the cycle after the edge that sampled `vend_ack`/`cancel`.
- N coins of change take 2N cycles. `busy` drops on the edge after the last pulse cycle.
- Reset asserted mid-PAYOUT or mid-VEND:
  - Immediate return to IDLE.
  - Remaining credit/payout is discarded.
  - `chg_pulse` forced low without waiting for the clock.
- `coin`=11 is never rejected and never pulses `coin_rej`.
- `vend_ack` held high across several cycles acts once. IDLE/COLLECT ignore it.

## Test plan
- Reset with `coin`=00 held: all outputs at reset values; segments 1000000. Release reset: credit 25 after first edge, digits 0,2,5.
- PRICE=100, four 25-paise coins: digits 025, 050, 075, 100. `done`=1 only after the 4th edge. `vend_ack` → `done`=0, `busy`=0 next edge, no `chg_pulse`.
- PRICE=100, coins 50 then 100: credit 150, `done`=1. `vend_ack` → two `chg_pulse` on alternate cycles. Display 050 then 025 then IDLE 000.
- PRICE=150, coins 25, 50, then `cancel` together with coin 10: `coin_rej` pulses. Three `chg_pulse` (refund 75). Credit never reaches 175.
- In VEND, insert coin 01: `coin_rej`=1 one cycle, display unchanged. Assert `cancel` and `vend_ack` same cycle: vend wins, change = credit−PRICE.
- PRICE=875: coins to credit 950. Display digits 9,5,0. `vend_ack` yields 3 pulses. Assert `reset` low after the first pulse: outputs return to reset values asynchronously.
